// File: rtl/data_memory_lsu.sv
// Byte-addressable RV32I data memory with valid/ready requests,
// fixed response latency and fault reporting for bad accesses.
module data_memory_lsu #(
    parameter int DEPTH_BYTES  = 4096,
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] fault_addr
);
    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, next_state;
    logic [7:0]      mem [DEPTH_BYTES];
    logic [2:0]      cnt;
    logic            accept, illegal, misalign, oob, fault;
    logic [2:0]      size;
    logic [ADDR_W:0] end_addr;
    logic [AW-1:0]   base;
    logic [31:0]     raw, ld_val, pend_rdata;
    logic            pend_fault;

    assign req_ready  = rst_n && (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);
    assign base       = req_addr[AW-1:0];

    always_comb begin
        size    = 3'd4;
        illegal = 1'b0;
        unique case (req_funct3)
            3'b000, 3'b100: size = 3'd1;
            3'b001, 3'b101: size = 3'd2;
            3'b010:         size = 3'd4;
            default:        illegal = 1'b1;
        endcase
        if (req_we && req_funct3[2])
            illegal = 1'b1;
        misalign = ((size == 3'd2) && req_addr[0]) ||
                   ((size == 3'd4) && (req_addr[1:0] != 2'b00));
        // One extra bit so an access near the top of the address space cannot wrap
        end_addr = {1'b0, req_addr} + (ADDR_W+1)'(size);
        oob      = end_addr > (ADDR_W+1)'(DEPTH_BYTES);
        fault    = illegal || misalign || oob;
    end

    assign raw = {mem[base + AW'(3)], mem[base + AW'(2)],
                  mem[base + AW'(1)], mem[base]};

    always_comb begin
        ld_val = 32'd0;
        if (!fault && !req_we) begin
            unique case (req_funct3)
                3'b000:  ld_val = {{24{raw[7]}}, raw[7:0]};
                3'b001:  ld_val = {{16{raw[15]}}, raw[15:0]};
                3'b100:  ld_val = {24'd0, raw[7:0]};
                3'b101:  ld_val = {16'd0, raw[15:0]};
                default: ld_val = raw;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (accept)
                      next_state = (READ_LATENCY == 1) ? RESP : WAIT;
            WAIT: if (cnt == 3'(READ_LATENCY - 1))
                      next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            pend_rdata <= 32'd0;
            pend_fault <= 1'b0;
            resp_rdata <= 32'd0;
            resp_fault <= 1'b0;
            fault_addr <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                cnt        <= 3'd1;
                pend_rdata <= ld_val;
                pend_fault <= fault;
                if (fault)
                    fault_addr <= req_addr;
                if (READ_LATENCY == 1) begin
                    resp_rdata <= ld_val;
                    resp_fault <= fault;
                end
            end else if (state == WAIT) begin
                cnt <= cnt + 3'd1;
                if (next_state == RESP) begin
                    resp_rdata <= pend_rdata;
                    resp_fault <= pend_fault;
                end
            end
        end
    end

    // Storage is deliberately left out of reset; accept already excludes reset cycles
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (accept && req_we && !fault && (3'(k) < size))
                mem[base + AW'(k)] <= req_wdata[8*k +: 8];
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu: one instance with latency 1,
// one with latency 3, both 4 KiB deep.
module tb_data_memory_lsu;
    logic        clk;
    logic [1:0]  rst_n;
    logic [1:0]  valid;
    logic [1:0]  rdy;
    logic [1:0]  we;
    logic [2:0]  f3 [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [1:0]  rv;
    logic [31:0] rdata [2];
    logic [1:0]  flt;
    logic [31:0] fa [2];

    int n_tests = 0;
    int n_fail  = 0;

    data_memory_lsu #(.DEPTH_BYTES(4096), .READ_LATENCY(1), .ADDR_W(32)) u_lat1 (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(valid[0]), .req_ready(rdy[0]), .req_we(we[0]),
        .req_funct3(f3[0]), .req_addr(addr[0]), .req_wdata(wdata[0]),
        .resp_valid(rv[0]), .resp_rdata(rdata[0]), .resp_fault(flt[0]),
        .fault_addr(fa[0])
    );

    data_memory_lsu #(.DEPTH_BYTES(4096), .READ_LATENCY(3), .ADDR_W(32)) u_lat3 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(valid[1]), .req_ready(rdy[1]), .req_we(we[1]),
        .req_funct3(f3[1]), .req_addr(addr[1]), .req_wdata(wdata[1]),
        .resp_valid(rv[1]), .resp_rdata(rdata[1]), .resp_fault(flt[1]),
        .fault_addr(fa[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input int d, input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ef,
                        input int el, input string tag);
        int n;
        @(negedge clk);
        valid[d] = 1'b1;
        we[d]    = w;
        f3[d]    = f;
        addr[d]  = a;
        wdata[d] = wd;
        n = 0;
        while (!rdy[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".accept"}, 32'(rdy[d]), 32'd1);
        @(posedge clk);
        #1;
        valid[d] = 1'b0;
        n = 1;
        while (!rv[d] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(el));
        chk({tag, ".rdata"}, rdata[d], er);
        chk({tag, ".fault"}, 32'(flt[d]), 32'(ef));
        @(posedge clk);
        #1;
        chk({tag, ".pulse"}, 32'(rv[d]), 32'd0);
    endtask

    initial begin
        int acc_t [2];
        int rsp_t [2];
        int na, nr, rdy_busy, seen;
        logic [31:0] rsp_d [2];

        rst_n = 2'b00;
        valid = 2'b00;
        we    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            f3[i]    = 3'b010;
            addr[i]  = 32'd0;
            wdata[i] = 32'd0;
        end
        repeat (2) @(negedge clk);
        chk("rst.ready0", 32'(rdy[0]), 32'd0);
        chk("rst.ready1", 32'(rdy[1]), 32'd0);
        chk("rst.rvalid", 32'(rv), 32'd0);
        chk("rst.rdata", rdata[0], 32'd0);
        chk("rst.fault", 32'(flt), 32'd0);
        chk("rst.faddr", fa[0], 32'd0);
        rst_n = 2'b11;
        @(negedge clk);
        chk("idle.ready", 32'(rdy), 32'd3);

        xfer(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1, "sw10");
        xfer(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1, "lw10");
        xfer(0, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 1, "lb13");
        xfer(0, 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, 1, "lbu13");
        xfer(0, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 1, "lh12");
        xfer(0, 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 1, "lhu10");
        xfer(0, 1'b1, 3'b000, 32'h11, 32'hAAAAAA7F, 32'h0, 1'b0, 1, "sb11");
        xfer(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0, 1, "lw10b");
        xfer(0, 1'b1, 3'b001, 32'h11, 32'h00001234, 32'h0, 1'b1, 1, "sh11");
        chk("sh11.faddr", fa[0], 32'h11);
        xfer(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0, 1, "lw10c");
        chk("sticky.faddr", fa[0], 32'h11);
        xfer(0, 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 1, "lw12mis");
        xfer(0, 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, 1, "lw1000");
        chk("lw1000.faddr", fa[0], 32'h1000);
        xfer(0, 1'b0, 3'b001, 32'hFFF, 32'h0, 32'h0, 1'b1, 1, "lhfff");
        chk("lhfff.faddr", fa[0], 32'hFFF);
        xfer(0, 1'b1, 3'b010, 32'hFFC, 32'h80000001, 32'h0, 1'b0, 1, "swffc");
        xfer(0, 1'b0, 3'b000, 32'hFFF, 32'h0, 32'hFFFFFF80, 1'b0, 1, "lbfff");
        xfer(0, 1'b0, 3'b010, 32'hFFC, 32'h0, 32'h80000001, 1'b0, 1, "lwffc");
        xfer(0, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, "f3_011");
        xfer(0, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 1, "sbu");
        chk("sbu.faddr", fa[0], 32'h10);
        xfer(0, 1'b1, 3'b110, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 1, "s110");
        xfer(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0, 1, "nowrite");

        // Latency 3: store then load held valid back-to-back
        na = 0;
        nr = 0;
        rdy_busy = 0;
        acc_t = '{0, 0};
        rsp_t = '{0, 0};
        rsp_d = '{32'h0, 32'h0};
        @(negedge clk);
        valid[1] = 1'b1;
        we[1]    = 1'b1;
        f3[1]    = 3'b010;
        addr[1]  = 32'h40;
        wdata[1] = 32'hCAFEF00D;
        for (int i = 0; i < 14; i++) begin
            if (i > 0)
                @(negedge clk);
            if (rv[1] && nr < 2) begin
                rsp_t[nr] = i;
                rsp_d[nr] = rdata[1];
                nr++;
            end
            if (rdy[1] && valid[1] && na < 2) begin
                acc_t[na] = i;
                na++;
            end else if (rdy[1] && na == 1) begin
                rdy_busy++;
            end
            if (na == 1 && i == acc_t[0] + 1) begin
                we[1] = 1'b0;
                wdata[1] = 32'h0;
            end
            if (na == 2 && i == acc_t[1] + 1)
                valid[1] = 1'b0;
            if (na == 1 && i > acc_t[0] && i < acc_t[0] + 4 && rdy[1])
                rdy_busy++;
        end
        valid[1] = 1'b0;
        chk("b2b.naccept", 32'(na), 32'd2);
        chk("b2b.nresp", 32'(nr), 32'd2);
        chk("b2b.spacing", 32'(acc_t[1] - acc_t[0]), 32'd4);
        chk("b2b.lat0", 32'(rsp_t[0] - acc_t[0]), 32'd3);
        chk("b2b.lat1", 32'(rsp_t[1] - acc_t[1]), 32'd3);
        chk("b2b.busyready", 32'(rdy_busy), 32'd0);
        chk("b2b.store_rd", rsp_d[0], 32'h0);
        chk("b2b.load_rd", rsp_d[1], 32'hCAFEF00D);

        xfer(1, 1'b0, 3'b011, 32'h44, 32'h0, 32'h0, 1'b1, 3, "l3fault");
        chk("l3fault.faddr", fa[1], 32'h44);
        xfer(1, 1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 3, "l3lw40");

        // Reset while a store is in WAIT, with a second store presented during reset
        @(negedge clk);
        valid[1] = 1'b1;
        we[1]    = 1'b1;
        f3[1]    = 3'b010;
        addr[1]  = 32'h20;
        wdata[1] = 32'h12345678;
        seen = 0;
        while (!rdy[1] && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        chk("rstw.accept", 32'(rdy[1]), 32'd1);
        @(posedge clk);
        #1;
        valid[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b0;
        valid[1] = 1'b1;
        wdata[1] = 32'hBAD0BAD0;
        chk("rstw.ready", 32'(rdy[1]), 32'd0);
        @(posedge clk);
        #1;
        chk("rstw.rvalid", 32'(rv[1]), 32'd0);
        chk("rstw.rdata", rdata[1], 32'd0);
        chk("rstw.fault", 32'(flt[1]), 32'd0);
        chk("rstw.faddr", fa[1], 32'd0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        valid[1] = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rv[1])
                seen++;
        end
        chk("rstw.noresp", 32'(seen), 32'd0);
        xfer(1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h12345678, 1'b0, 3, "rstw.lw20");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
